// File: rtl/luggage_stack_unit.sv
// luggage_stack_unit: groups of items are pushed onto a stack, popped LIFO at each
// delimiter by a host-given count, and drained FIFO at the end marker.
module luggage_stack_unit #(
    parameter int unsigned   DW    = 8,
    parameter int unsigned   DEPTH = 16,
    parameter int unsigned   CNTW  = $clog2(DEPTH + 1),
    parameter logic [DW-1:0] DELIM = DW'(8'h3B),
    parameter logic [DW-1:0] ENDM  = DW'(8'h24)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
    input  logic [CNTW-1:0] pop_num,
    output logic            in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic            out_mode,
    input  logic            out_ready,
    output logic            group_done,
    output logic            done,
    output logic            overflow,
    output logic            underflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_ACCEPT, S_POP, S_DRAIN, S_DONE} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [DW-1:0]   mem [DEPTH];
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_nxt;
    logic [CNTW-1:0] popcnt;
    logic [CNTW-1:0] popcnt_nxt;
    logic [CNTW-1:0] rd_idx;
    logic [CNTW-1:0] rd_idx_nxt;

    logic            out_valid_nxt;
    logic [DW-1:0]   out_data_nxt;
    logic            out_mode_nxt;
    logic            group_done_nxt;
    logic            done_nxt;
    logic            overflow_nxt;
    logic            underflow_nxt;
    logic            push_en;

    logic            accept;
    logic            hs;
    logic            is_delim;
    logic            is_end;
    logic            pop_over;
    logic [CNTW-1:0] pop_clip;
    logic            drain_last;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   top_idx;
    logic [AW-1:0]   below_top_idx;
    logic [AW-1:0]   next_rd_idx;

    // Handshake qualifiers and storage addresses
    assign in_ready      = (state == S_ACCEPT) && rst;
    assign accept        = in_valid && in_ready;
    assign hs            = out_valid && out_ready;
    assign is_delim      = (in_data == DELIM);
    assign is_end        = (in_data == ENDM);
    assign pop_over      = (pop_num > count);
    assign pop_clip      = pop_over ? count : pop_num;
    assign drain_last    = (CNTW'(rd_idx + CNTW'(1)) == count);
    assign wr_idx        = AW'(count);
    assign top_idx       = AW'(count - CNTW'(1));
    assign below_top_idx = AW'(count - CNTW'(2));
    assign next_rd_idx   = AW'(rd_idx + CNTW'(1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_ACCEPT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; zero-length groups and empty drains skip straight through
    always_comb begin
        state_nxt = state;
        case (state)
            S_ACCEPT: begin
                if (accept && is_delim) begin
                    state_nxt = (pop_clip == '0) ? S_ACCEPT : S_POP;
                end else if (accept && is_end) begin
                    state_nxt = (count == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_POP: begin
                if (popcnt == '0) begin
                    state_nxt = S_ACCEPT;
                end else if (hs && (popcnt == CNTW'(1))) begin
                    state_nxt = S_ACCEPT;
                end
            end
            S_DRAIN: begin
                if (rd_idx == count) begin
                    state_nxt = S_DONE;
                end else if (hs && drain_last) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_DONE;
        endcase
    end

    // Next values for registered outputs and datapath counters
    always_comb begin
        count_nxt      = count;
        popcnt_nxt     = popcnt;
        rd_idx_nxt     = rd_idx;
        out_valid_nxt  = out_valid;
        out_data_nxt   = out_data;
        out_mode_nxt   = out_mode;
        group_done_nxt = 1'b0;
        done_nxt       = (state_nxt == S_DONE);
        overflow_nxt   = overflow;
        underflow_nxt  = underflow;
        push_en        = 1'b0;
        case (state)
            S_ACCEPT: begin
                if (accept && is_delim) begin
                    popcnt_nxt = pop_clip;
                    if (pop_over) begin
                        underflow_nxt = 1'b1;
                    end
                    if (pop_clip == '0) begin
                        group_done_nxt = 1'b1;
                    end else begin
                        out_valid_nxt = 1'b1;
                        out_mode_nxt  = 1'b0;
                        out_data_nxt  = mem[top_idx];
                    end
                end else if (accept && is_end) begin
                    rd_idx_nxt = '0;
                    if (count != '0) begin
                        out_valid_nxt = 1'b1;
                        out_mode_nxt  = 1'b1;
                        out_data_nxt  = mem[0];
                    end
                end else if (accept) begin
                    if (count < CNTW'(DEPTH)) begin
                        push_en   = 1'b1;
                        count_nxt = count + CNTW'(1);
                    end else begin
                        overflow_nxt = 1'b1;
                    end
                end
            end
            S_POP: begin
                if (popcnt == '0) begin
                    out_valid_nxt  = 1'b0;
                    group_done_nxt = 1'b1;
                end else if (hs) begin
                    count_nxt  = count - CNTW'(1);
                    popcnt_nxt = popcnt - CNTW'(1);
                    if (popcnt == CNTW'(1)) begin
                        out_valid_nxt  = 1'b0;
                        group_done_nxt = 1'b1;
                    end else begin
                        out_data_nxt = mem[below_top_idx];
                    end
                end
            end
            S_DRAIN: begin
                if (rd_idx == count) begin
                    count_nxt     = '0;
                    out_valid_nxt = 1'b0;
                end else if (hs) begin
                    rd_idx_nxt = rd_idx + CNTW'(1);
                    if (drain_last) begin
                        count_nxt     = '0;
                        out_valid_nxt = 1'b0;
                    end else begin
                        out_data_nxt = mem[next_rd_idx];
                    end
                end
            end
            default: begin
                out_valid_nxt = 1'b0;
            end
        endcase
        if (state_nxt == S_DONE) begin
            count_nxt = '0;
        end
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            count      <= '0;
            popcnt     <= '0;
            rd_idx     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_mode   <= 1'b0;
            group_done <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= count_nxt;
            popcnt     <= popcnt_nxt;
            rd_idx     <= rd_idx_nxt;
            out_valid  <= out_valid_nxt;
            out_data   <= out_data_nxt;
            out_mode   <= out_mode_nxt;
            group_done <= group_done_nxt;
            done       <= done_nxt;
            overflow   <= overflow_nxt;
            underflow  <= underflow_nxt;
        end
    end

    // Item storage; only written on an accepted push
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_idx] <= in_data;
        end
    end

endmodule

// File: tb/tb_luggage_stack_unit.sv
// Bench for luggage_stack_unit: directed vector table, hand-written corner
// sequences, and randomized streams scored against a queue-based model.
module tb_luggage_stack_unit;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNTW  = $clog2(DEPTH + 1);
    localparam logic [7:0]  DELIM = 8'h3B;
    localparam logic [7:0]  ENDM  = 8'h24;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic [CNTW-1:0] pop_num;
    logic            in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_mode;
    logic            out_ready;
    logic            group_done;
    logic            done;
    logic            overflow;
    logic            underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    luggage_stack_unit #(
        .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW), .DELIM(DELIM), .ENDM(ENDM)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .pop_num(pop_num), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_mode(out_mode), .out_ready(out_ready),
        .group_done(group_done), .done(done), .overflow(overflow), .underflow(underflow)
    );

    typedef struct packed {
        logic            rst;
        logic            iv;
        logic [7:0]      data;
        logic [CNTW-1:0] pop;
        logic            ordy;
        logic            ov;
        logic [7:0]      od;
        logic            om;
        logic            gd;
        logic            dn;
        logic            ir;
        logic            of;
        logic            uf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic iv, input logic [7:0] d, input int p,
                       input logic ordy, input logic ov, input logic [7:0] od, input logic om,
                       input logic gd, input logic dn, input logic ir, input logic of,
                       input logic uf);
        vec_t v;
        v.rst = r; v.iv = iv; v.data = d; v.pop = CNTW'(p); v.ordy = ordy;
        v.ov = ov; v.od = od; v.om = om; v.gd = gd; v.dn = dn; v.ir = ir;
        v.of = of; v.uf = uf;
        vecs.push_back(v);
    endtask

    task automatic apply_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pop_num = '0; in_data = '0;
        tick();
        rst = 1'b1;
    endtask

    // One randomized episode: random stream ending in ENDM, random gaps and stalls
    task automatic run_random(input int n_beats, input int item_pct);
        logic [7:0]      stk[$];
        logic [8:0]      exp_q[$];
        logic [7:0]      s_data[$];
        logic [CNTW-1:0] s_pop[$];
        logic [8:0]      held;
        logic [8:0]      e;
        logic [7:0]      d;
        bit              m_ovf = 0;
        bit              m_unf = 0;
        bit              ended = 0;
        bit              finished = 0;
        bit              stall = 0;
        int              m_groups = 0;
        int              seen_groups = 0;
        int              idx = 0;
        int              n;
        for (int i = 0; i < n_beats; i++) begin
            if ($urandom_range(0, 99) < item_pct) begin
                do d = 8'($urandom_range(0, 255)); while (d == DELIM || d == ENDM);
                s_data.push_back(d);
            end else begin
                s_data.push_back(DELIM);
            end
            if ($urandom_range(0, 9) == 0) s_pop.push_back(CNTW'($urandom_range(0, 31)));
            else                           s_pop.push_back(CNTW'($urandom_range(0, 4)));
        end
        s_data.push_back(ENDM);
        s_pop.push_back('0);
        apply_reset();
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            if (!ended && idx < s_data.size()) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = s_data[idx];
                pop_num  = s_pop[idx];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (stall) begin
                check("rnd stall valid held", out_valid, 1);
                check("rnd stall data held", {out_mode, out_data}, held);
            end
            if (exp_q.size() != 0 || ended) check("rnd in_ready low while busy", in_ready, 0);
            if (group_done) seen_groups++;
            if (done) begin
                check("rnd done with outputs pending", exp_q.size(), 0);
                finished = 1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd spurious output", {out_mode, out_data}, 9'h1FF);
                    n_checks++; n_fail++;
                    $display("FAIL rnd unexpected handshake: got 0x%0h, expected none", {out_mode, out_data});
                end else begin
                    e = exp_q.pop_front();
                    check("rnd output item", {out_mode, out_data}, e);
                end
            end
            stall = out_valid && !out_ready;
            held  = {out_mode, out_data};
            if (in_valid && in_ready) begin
                if (in_data == DELIM) begin
                    n = (int'(pop_num) > stk.size()) ? stk.size() : int'(pop_num);
                    if (int'(pop_num) > stk.size()) m_unf = 1;
                    repeat (n) exp_q.push_back({1'b0, stk.pop_back()});
                    m_groups++;
                end else if (in_data == ENDM) begin
                    while (stk.size() != 0) exp_q.push_back({1'b1, stk.pop_front()});
                    ended = 1;
                end else if (stk.size() < DEPTH) begin
                    stk.push_back(in_data);
                end else begin
                    m_ovf = 1;
                end
                idx++;
            end
            tick();
        end
        check("rnd reached done", finished, 1);
        check("rnd group_done pulses", seen_groups, m_groups);
        check("rnd overflow flag", overflow, m_ovf);
        check("rnd underflow flag", underflow, m_unf);
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; pop_num = '0; out_ready = 1'b0;

        //   rst iv data   pop ordy | ov od    om gd dn ir of uf
        // push 41 42 43, pop 2, drain remaining, DONE ignores input
        add(0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 0);
        add(1, 1, 8'h41, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, 8'h42, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, 8'h43, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, DELIM, 2, 1,   1, 8'h43, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1,   1, 8'h42, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 1, ENDM,  0, 1,   1, 8'h41, 1, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 0, 0, 0);
        add(1, 1, 8'h41, 0, 1,   0, 8'h00, 0, 0, 1, 0, 0, 0);
        // zero-length group
        add(0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 0);
        add(1, 1, 8'h58, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, DELIM, 0, 1,   0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 1, ENDM,  0, 1,   1, 8'h58, 1, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 0, 0, 0);
        // underflow: ask for 3 with one stored
        add(0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 0);
        add(1, 1, 8'h41, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, DELIM, 3, 1,   1, 8'h41, 0, 0, 0, 0, 0, 1);
        add(1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 1, 0, 1, 0, 1);
        add(1, 1, ENDM,  0, 1,   0, 8'h00, 0, 0, 1, 0, 0, 1);
        add(1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 1, 0, 0, 1);
        // pop 3 with ready pattern 1,0,0,1,1
        add(0, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 0, 0, 0);
        add(1, 1, 8'h10, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, 8'h11, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, 8'h12, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);
        add(1, 1, DELIM, 3, 1,   1, 8'h12, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1,   1, 8'h11, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0,   1, 8'h11, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 0,   1, 8'h11, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1,   1, 8'h10, 0, 0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 1, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 1,   0, 8'h00, 0, 0, 0, 1, 0, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_valid = vecs[i].iv; in_data = vecs[i].data;
            pop_num = vecs[i].pop; out_ready = vecs[i].ordy;
            tick();
            check($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
            if (vecs[i].ov) begin
                check($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
                check($sformatf("vec%0d out_mode", i), out_mode, vecs[i].om);
            end
            check($sformatf("vec%0d group_done", i), group_done, vecs[i].gd);
            check($sformatf("vec%0d done", i), done, vecs[i].dn);
            check($sformatf("vec%0d in_ready", i), in_ready, vecs[i].ir);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].of);
            check($sformatf("vec%0d underflow", i), underflow, vecs[i].uf);
        end

        // Overflow: 17 pushes into 16 slots, then drain in arrival order
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h41 + i);
            tick();
            if (i == 15) check("ovf clear at full", overflow, 0);
        end
        check("ovf set after drop", overflow, 1);
        in_data = ENDM; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check($sformatf("ovf drain valid %0d", j), out_valid, 1);
            check($sformatf("ovf drain item %0d", j), {out_mode, out_data}, {1'b1, 8'(8'h41 + j)});
            tick();
        end
        check("ovf drain done", done, 1);
        check("ovf drain valid low", out_valid, 0);

        // Reset in the middle of a drain
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h61 + i);
            tick();
        end
        in_data = ENDM;
        tick();
        in_valid = 1'b0;
        check("rstmid item0", {out_valid, out_data}, {1'b1, 8'h61});
        tick();
        check("rstmid item1", {out_valid, out_data}, {1'b1, 8'h62});
        tick();
        rst = 1'b0;
        #1;
        check("rstmid in_ready during reset", in_ready, 0);
        tick();
        check("rstmid outputs cleared",
              {out_valid, out_data, out_mode, group_done, done, overflow, underflow}, '0);
        check("rstmid in_ready held low", in_ready, 0);
        rst = 1'b1;
        #1;
        check("rstmid in_ready after release", in_ready, 1);
        in_valid = 1'b1; in_data = ENDM;
        tick();
        in_valid = 1'b0;
        check("rstmid empty drain done", done, 1);
        check("rstmid empty drain no output", out_valid, 0);
        check("rstmid flags clear", {overflow, underflow}, 2'b00);

        run_random(30, 70);
        run_random(45, 95);
        run_random(25, 50);
        run_random(40, 80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/luggage_stack_unit.md
# luggage_stack_unit

Parametrised successor to the check-in baggage handler in the CIPU family. It accepts a byte stream of items split into groups by a delimiter. At each delimiter it pops a host-specified number of items in LIFO order. At the end marker it drains all remaining items in arrival (FIFO) order. Width, depth and marker codes are parameters, and both output paths obey valid/ready backpressure with overflow and underflow reporting.

## Interface
- DW, 8, item/data width
- DEPTH, 16, stack capacity in items
- CNTW, $clog2(DEPTH+1), width of pop count
- DELIM, 8'h3B, group delimiter code (';')
- ENDM, 8'h24, end-of-stream code ('$')

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  input item present
- in_data  in  DW  item, DELIM or ENDM
- pop_num  in  CNTW  items to pop; sampled only on an accepted DELIM beat
- in_ready  out  1  block can accept an input beat
- out_valid  out  1  out_data valid
- out_data  out  DW  popped or drained item
- out_mode  out  1  0 = LIFO pop, 1 = FIFO drain
- out_ready  in  1  downstream accepts out_data
- group_done  out  1  one-cycle pulse when a group's pops complete
- done  out  1  level; stream fully drained
- overflow  out  1  sticky; an item was dropped because the stack was full
- underflow  out  1  sticky; pop_num exceeded the stored count

## Operation
- Storage: array mem[0:DEPTH-1] plus count register (0..DEPTH). Push writes mem[count]. LIFO pop reads mem[count-1]. Drain reads mem[rd_idx] with rd_idx running from 0 to count-1. No wrap-around.
- States: ACCEPT, POP, DRAIN, DONE. Reset state is ACCEPT.
- in_ready = (state==ACCEPT) && rst. A beat is accepted when in_valid && in_ready.
- ACCEPT, data item:
  - If count<DEPTH, push it.
  - Otherwise drop it and set overflow.
- ACCEPT, DELIM:
  - popcnt <= min(pop_num, count).
  - If pop_num>count, set underflow.
  - Go to POP.
- ACCEPT, ENDM: rd_idx <= 0; go to DRAIN.
- POP:
  - If popcnt==0: pulse group_done and go to ACCEPT.
  - Otherwise out_valid=1, out_mode=0, out_data=mem[count-1].
  - Each handshake decrements count and popcnt.
  - After the last handshake: pulse group_done and go to ACCEPT.
- DRAIN:
  - If rd_idx==count (including count==0 at entry): count <= 0, go to DONE.
  - Otherwise out_valid=1, out_mode=1, out_data=mem[rd_idx]; each handshake increments rd_idx.
- DONE: done=1, in_ready=0, out_valid=0. Inputs are ignored until reset.
- Outputs are registered and change only on clk edges.
- out_data and out_mode hold stable while out_valid && !out_ready.

## Timing
- Reset (rst=0 at an edge) takes effect at that edge from any state, mid-operation included:
  - state ACCEPT, count 0, popcnt 0, rd_idx 0.
  - out_valid, out_data, out_mode, group_done, done, overflow, underflow all 0.
  - in_ready is 0 while rst=0 and 1 in the first cycle after rst=1.
- DELIM accepted at edge t:
  - popcnt>0: out_valid=1 from cycle t+1 with the top item.
  - popcnt==0: group_done=1 in cycle t+1, and in_ready=1 again in t+1.
- Back-to-back outputs: a handshake at edge k presents the next item in cycle k+1, with no bubbles.
- Last pop handshake at edge k: in cycle k+1, out_valid=0, group_done=1 for exactly one cycle, and in_ready=1.
- ENDM accepted at t:
  - count>0: first drained item is valid at t+1.
  - count==0: done=1 at t+1.
  - Last drain handshake at k: done=1 at k+1.
- Pushing when count==DEPTH: item discarded, count unchanged, overflow=1 from the next cycle.
- Sticky flags clear only on reset.

## Test plan
- Push 0x41, 0x42, 0x43, then DELIM with pop_num=2, out_ready=1 -> out 0x43, 0x42 with out_mode=0 on consecutive cycles, group_done one cycle after 0x42. Then ENDM -> 0x41 with out_mode=1, then done=1.
- Push 0x58, then DELIM with pop_num=0 -> no out_valid, group_done=1 at t+1, in_ready=1 at t+1. Then ENDM -> 0x58 drained, done.
- Pop 3 items with out_ready pattern 1,0,0,1,1 -> out_data stable during stalls, order preserved, exactly 3 handshakes, then group_done.
- Push 17 items 0x41..0x51 (DEPTH=16) -> 0x51 dropped and overflow=1. ENDM -> drains 0x41..0x50 in order, then done=1.
- Push 0x41, then DELIM with pop_num=3 -> single output 0x41, underflow=1, group_done. Then ENDM -> done=1 at t+1 with no out_valid.
- Reset held for one edge during DRAIN, after 2 of 5 items -> all outputs 0 and in_ready=0 during reset. After release, ENDM -> done at t+1 with no out_valid. Overflow and underflow read 0.
